// File: rtl/seq_hit_pkg.sv
// Shared definitions for the sequence-detector hit buffer.
// These cover the entry layout, the detector mode encodings and a constant clog2 helper.
package seq_hit_pkg;

  localparam int ENTRY_W = 6;
  localparam int MODE_W  = 2;
  localparam int DATA_W  = 4;

  typedef enum logic [MODE_W-1:0] {
    MODE_INC = 2'd0,
    MODE_DEC = 2'd1,
    MODE_EQ  = 2'd2
  } mode_e;

  typedef struct packed {
    logic [MODE_W-1:0] mode;
    logic [DATA_W-1:0] data;
  } entry_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result = result + 1;
    return result;
  endfunction

endpackage

// File: rtl/seq_hit_fifo.sv
// Generic first-word-fall-through FIFO with registered occupancy flags.
// When the FIFO is full, a push is still accepted if a pop happens in the same cycle.
module seq_hit_fifo
  import seq_hit_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 6
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clr,
  input  logic                   i_push_req,
  input  logic [W-1:0]           i_din,
  input  logic                   i_pop_req,
  output logic [W-1:0]           o_head,
  output logic                   o_valid,
  output logic                   o_full,
  output logic [clog2(DEPTH):0]  o_level,
  output logic                   o_accept
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [LW-1:0] r_wr_ptr;
  logic [LW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_valid;
  logic          r_full;

  logic          w_push;
  logic          w_pop;
  logic [LW-1:0] w_level_next;

  always_comb begin
    w_pop  = r_valid & i_pop_req;
    w_push = i_push_req & (~r_full | w_pop);
    w_level_next = r_level;
    if (w_push && !w_pop) begin
      w_level_next = r_level + LW'(1);
    end else if (!w_push && w_pop) begin
      w_level_next = r_level - LW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_valid  <= 1'b0;
      r_full   <= 1'b0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_valid  <= 1'b0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + LW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + LW'(1);
      r_level <= w_level_next;
      r_valid <= (w_level_next != '0);
      r_full  <= (w_level_next == LW'(DEPTH));
    end
  end

  // Storage has no reset, so it can map onto distributed or block memory.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_clr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end
  end

  assign o_head   = r_mem[r_rd_ptr[AW-1:0]];
  assign o_valid  = r_valid;
  assign o_full   = r_full;
  assign o_level  = r_level;
  assign o_accept = w_push & ~i_clr;

endmodule

// File: rtl/seq_hit_buffer.sv
// Captures detector events {MODE, DATA} into a FWFT FIFO and drains them through valid/ready.
// It also keeps a saturating hit counter and a sticky overflow flag for dropped events.
module seq_hit_buffer
  import seq_hit_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                   SYSCLK,
  input  logic                   RST,
  input  logic                   CLR,
  input  logic                   IN_VALID,
  input  logic [MODE_W-1:0]      MODE,
  input  logic [DATA_W-1:0]      DATA_IN,
  input  logic                   OUT_READY,
  output logic                   OUT_VALID,
  output logic [ENTRY_W-1:0]     DATA_OUT,
  output logic [clog2(DEPTH):0]  LEVEL,
  output logic                   FULL,
  output logic [CNT_W-1:0]       HIT_CNT,
  output logic                   OVERFLOW
);

  entry_t               w_entry;
  logic [ENTRY_W-1:0]   w_head;
  logic                 w_valid;
  logic                 w_accept;
  logic                 w_drop;
  logic [CNT_W-1:0]     r_hit_cnt;
  logic                 r_overflow;

  assign w_entry = '{mode: MODE, data: DATA_IN};

  seq_hit_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .i_clk      (SYSCLK),
    .i_rst      (RST),
    .i_clr      (CLR),
    .i_push_req (IN_VALID),
    .i_din      (w_entry),
    .i_pop_req  (OUT_READY),
    .o_head     (w_head),
    .o_valid    (w_valid),
    .o_full     (FULL),
    .o_level    (LEVEL),
    .o_accept   (w_accept)
  );

  // An event is dropped only when the FIFO is full and nothing is popped in that cycle.
  assign w_drop = IN_VALID & ~CLR & ~w_accept;

  always_ff @(posedge SYSCLK or posedge RST) begin
    if (RST) begin
      r_hit_cnt  <= '0;
      r_overflow <= 1'b0;
    end else if (CLR) begin
      r_hit_cnt  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (IN_VALID && !(&r_hit_cnt)) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign OUT_VALID = w_valid;
  assign DATA_OUT  = w_valid ? w_head : '0;
  assign HIT_CNT   = r_hit_cnt;
  assign OVERFLOW  = r_overflow;

endmodule

// File: tb/tb_seq_hit_buffer.sv
// Directed and randomized checks of seq_hit_buffer against a queue-based reference model.
module tb_seq_hit_buffer;

  localparam int DEPTH = 8;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic       SYSCLK;
  logic       RST;
  logic       CLR;
  logic       IN_VALID;
  logic [1:0] MODE;
  logic [3:0] DATA_IN;
  logic       OUT_READY;
  logic       OUT_VALID;
  logic [5:0] DATA_OUT;
  logic [3:0] LEVEL;
  logic       FULL;
  logic [7:0] HIT_CNT;
  logic       OVERFLOW;

  seq_hit_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .SYSCLK    (SYSCLK),
    .RST       (RST),
    .CLR       (CLR),
    .IN_VALID  (IN_VALID),
    .MODE      (MODE),
    .DATA_IN   (DATA_IN),
    .OUT_READY (OUT_READY),
    .OUT_VALID (OUT_VALID),
    .DATA_OUT  (DATA_OUT),
    .LEVEL     (LEVEL),
    .FULL      (FULL),
    .HIT_CNT   (HIT_CNT),
    .OVERFLOW  (OVERFLOW)
  );

  initial SYSCLK = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  // Reference model: queue of stored entries, hit count, sticky overflow.
  logic [5:0] mq[$];
  int         m_cnt;
  bit         m_ovf;
  int         n_vec;
  int         n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic iv, input logic [1:0] m, input logic [3:0] d,
                            input logic rdy, input logic clr);
    bit pop;
    if (clr) begin
      mq.delete();
      m_cnt = 0;
      m_ovf = 1'b0;
    end else begin
      pop = (mq.size() > 0) && rdy;
      if (iv && m_cnt < CMAX) m_cnt++;
      if (pop) void'(mq.pop_front());
      if (iv) begin
        if (mq.size() < DEPTH) mq.push_back({m, d});
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, 32'(OUT_VALID), 32'(mq.size() != 0));
    chk({tag, ".data"},  32'(DATA_OUT),  (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    chk({tag, ".level"}, 32'(LEVEL),     32'(mq.size()));
    chk({tag, ".full"},  32'(FULL),      32'(mq.size() == DEPTH));
    chk({tag, ".hit"},   32'(HIT_CNT),   32'(m_cnt));
    chk({tag, ".ovf"},   32'(OVERFLOW),  32'(m_ovf));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".valid"}, 32'(OUT_VALID), 32'd0);
    chk({tag, ".data"},  32'(DATA_OUT),  32'd0);
    chk({tag, ".level"}, 32'(LEVEL),     32'd0);
    chk({tag, ".full"},  32'(FULL),      32'd0);
    chk({tag, ".hit"},   32'(HIT_CNT),   32'd0);
    chk({tag, ".ovf"},   32'(OVERFLOW),  32'd0);
  endtask

  task automatic cycle(input string tag, input logic iv, input logic [1:0] m,
                       input logic [3:0] d, input logic rdy, input logic clr);
    IN_VALID  = iv;
    MODE      = m;
    DATA_IN   = d;
    OUT_READY = rdy;
    CLR       = clr;
    @(posedge SYSCLK);
    model_step(iv, m, d, rdy, clr);
    #1;
    check_model(tag);
  endtask

  initial begin
    n_vec = 0; n_err = 0; m_cnt = 0; m_ovf = 1'b0;
    RST = 1'b1; CLR = 1'b0; IN_VALID = 1'b0; MODE = 2'd0; DATA_IN = 4'd0; OUT_READY = 1'b0;

    // Reset held with strobes present: everything stays zero.
    for (int i = 0; i < 3; i++) begin
      IN_VALID = i[0]; DATA_IN = 4'(i + 3);
      @(posedge SYSCLK); #1;
      check_zero("reset");
    end
    #2 RST = 1'b0;
    for (int i = 0; i < 3; i++) cycle("idle", 1'b0, 2'd0, 4'd0, 1'b0, 1'b0);

    // Single event, one-cycle latency, then drain.
    cycle("single", 1'b1, 2'd1, 4'd9, 1'b0, 1'b0);
    chk("single.exact", 32'(DATA_OUT), 32'h19);
    cycle("single_pop", 1'b0, 2'd0, 4'd0, 1'b1, 1'b0);
    chk("single_pop.empty", 32'(DATA_OUT), 32'd0);

    // Fill past capacity: two drops, overflow set.
    for (int i = 0; i < 10; i++) cycle("fill", 1'b1, 2'(i), 4'(i), 1'b0, 1'b0);
    chk("fill.full", 32'(FULL), 32'd1);
    chk("fill.ovf", 32'(OVERFLOW), 32'd1);
    for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, 2'd0, 4'd0, 1'b1, 1'b0);

    // Simultaneous push and pop when full: no drop.
    cycle("clr", 1'b1, 2'd2, 4'd5, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) cycle("fill8", 1'b1, 2'd3, 4'(i), 1'b0, 1'b0);
    cycle("simul", 1'b1, 2'd3, 4'd11, 1'b1, 1'b0);
    chk("simul.level", 32'(LEVEL), 32'd8);
    chk("simul.ovf", 32'(OVERFLOW), 32'd0);
    for (int i = 0; i < DEPTH; i++) cycle("drain2", 1'b0, 2'd0, 4'd0, 1'b1, 1'b0);

    // Counter saturation under sustained full-rate traffic.
    for (int i = 0; i < 300; i++)
      cycle("sat", 1'b1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'b1, 1'b0);
    chk("sat.hit", 32'(HIT_CNT), 32'd255);
    cycle("clr_iv", 1'b1, 2'd1, 4'd7, 1'b1, 1'b1);

    // Randomized mix with occasional clears.
    for (int i = 0; i < 400; i++)
      cycle("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 60) == 0));

    // Asynchronous reset between edges with five entries stored.
    cycle("pre_rst", 1'b0, 2'd0, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle("load5", 1'b1, 2'd2, 4'(i + 1), 1'b0, 1'b0);
    chk("load5.level", 32'(LEVEL), 32'd5);
    IN_VALID = 1'b0;
    #2 RST = 1'b1;
    #1 check_zero("async_rst");
    mq.delete(); m_cnt = 0; m_ovf = 1'b0;
    #2 RST = 1'b0;
    for (int i = 0; i < 4; i++) cycle("post_rst", 1'b1, 2'd1, 4'(i), 1'(i[0]), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
